param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits (1..256).
REQ-002 Parameter DEPTH, default 4, number of entries; power of two, 2..1024.
REQ-003 Parameter AFULL_LVL, default DEPTH-1, almost-full asserts when count >= AFULL_LVL.
REQ-004 Parameter AEMPTY_LVL, default 1, almost-empty asserts when count <= AEMPTY_LVL.
REQ-005 Clk  input  1  single clock; all logic on the rising edge.
REQ-006 Rst  input  1  reset, asynchronous, active-high.
REQ-007 Clr  input  1  synchronous flush.
REQ-008 Write  input  1  write request.
REQ-009 DIn  input  WIDTH  write data.
REQ-010 Read  input  1  read request.
REQ-011 DOut  output  WIDTH  read data, registered.
REQ-012 DValid  output  1  DOut holds a word popped on the previous cycle.
REQ-013 Empty, Full, AEmpty, AFull  output  1 each  status flags.
REQ-014 Count  output  clog2(DEPTH)+1  occupancy, 0..DEPTH.
REQ-015 Ovf, Udf  output  1 each  sticky overflow/underflow flags.

Function
REQ-016 Write accepted (push) iff Write=1 and Full=0; a push stores DIn at wr_ptr and increments wr_ptr modulo DEPTH.
REQ-017 Read accepted (pop) iff Read=1 and Empty=0; a pop loads DOut with mem[rd_ptr] on the same edge and increments rd_ptr modulo DEPTH.
REQ-018 Read latency 1 cycle: DValid=1 in the cycle after a pop, else 0.
REQ-019 DOut holds its last value when no pop occurs; it never returns to zero except on Rst.
REQ-020 Count: +1 on push only, -1 on pop only, unchanged on push+pop or on neither.
REQ-021 Push and pop in the same cycle at any non-full, non-empty level are both accepted; Count unchanged.
REQ-022 At Full, Write is rejected even when a simultaneous pop is accepted; at Empty, Read is rejected even when a simultaneous push is accepted (no fall-through).
REQ-023 Empty=(Count==0), Full=(Count==DEPTH), AFull=(Count>=AFULL_LVL), AEmpty=(Count<=AEMPTY_LVL); all decoded from the registered next Count, so flags change on the same edge as Count.
REQ-024 Ovf sets on Write=1 while Full=1; Udf sets on Read=1 while Empty=1; both hold until Clr or Rst.
REQ-025 Pointers wrap from DEPTH-1 to 0 without a gap; Count stays at or below DEPTH at all times.
REQ-026 Clr=1 for one cycle: pointers and Count become 0, Empty=1, AEmpty=1, other flags 0, Ovf and Udf cleared, DValid=0; any Write/Read in that cycle is ignored; DOut is held.
REQ-027 Memory contents are not cleared by Rst or Clr.

Reset
REQ-028 On Rst=1, immediately and without a clock: pointers=0, Count=0, DOut=0, DValid=0, Empty=1, AEmpty=1, Full=0, AFull=0, Ovf=0, Udf=0.
REQ-029 Rst asserted mid-operation discards all stored words; the first push after release is written to entry 0.
REQ-030 Rst release is synchronised externally; the block adds no synchronizer.

Structure
REQ-031 A shared package fifo_pkg holds the clog2 function, pointer/count width derivation and the default WIDTH/DEPTH constants.
REQ-032 Storage is a sub-module param_fifo_mem: a simple dual-port array with 1 write port and 1 registered read port, no reset, inferable as distributed or block RAM.
REQ-033 Pointers, Count, flags and sticky bits live in param_fifo; no combinational path from Read/Write to any output.

Verification
REQ-034 Rst, then 4 pushes 0xA0..0xA3 (DEPTH=4) -> Count=4, Full=1, AFull=1 after the 3rd push; 4 pops -> DOut=0xA0..0xA3 each one cycle after its pop, DValid=1, Empty=1 at end.
REQ-035 Full, Write=1 with DIn=0xFF -> Count stays 4, Ovf=1 and stays set; later pops never return 0xFF.
REQ-036 Empty, Read=1 -> DValid=0, DOut unchanged, Udf=1; same cycle Write=1 with 0x55 -> Count=1, next Read returns 0x55.
REQ-037 Count=2, Write and Read together for 10 cycles with an incrementing pattern -> Count=2 throughout, data in order across pointer wrap.
REQ-038 Count=3, Clr with Write=1 -> Count=0, Empty=1, Ovf=Udf=0, pushed word absent; Rst asserted between edges mid-stream -> outputs reach reset values before the next edge.
REQ-039 Repeat REQ-034/037 with WIDTH=8, DEPTH=16, AFULL_LVL=12, AEMPTY_LVL=3 -> AFull toggles at Count 11->12, AEmpty at Count 4->3.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the parameterised FIFO.
// Anything that needs pointer or occupancy widths derives them here so every file agrees.
package fifo_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 4;

    typedef struct packed {
        logic empty;
        logic full;
        logic aempty;
        logic afull;
    } flags_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    // At least one pointer bit, even for degenerate depths.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return clog2(depth) + 1;
    endfunction

    function automatic flags_t decode_flags(input int cnt, input int depth,
                                            input int afull_lvl, input int aempty_lvl);
        flags_t f;
        f.empty  = (cnt == 0);
        f.full   = (cnt == depth);
        f.aempty = (cnt <= aempty_lvl);
        f.afull  = (cnt >= afull_lvl);
        return f;
    endfunction

endpackage

// File: rtl/param_fifo_if.sv
// Handshake/data bundle between a FIFO producer-consumer and param_fifo.
// The master side drives requests and write data; the slave side is the FIFO.
interface param_fifo_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int CW = cnt_w(DEPTH);

    logic             clr;
    logic             write;
    logic [WIDTH-1:0] din;
    logic             read;
    logic [WIDTH-1:0] dout;
    logic             dvalid;
    logic             empty;
    logic             full;
    logic             aempty;
    logic             afull;
    logic [CW-1:0]    count;
    logic             ovf;
    logic             udf;

    modport master (
        output clr, write, din, read,
        input  dout, dvalid, empty, full, aempty, afull, count, ovf, udf
    );

    modport slave (
        input  clr, write, din, read,
        output dout, dvalid, empty, full, aempty, afull, count, ovf, udf
    );

endinterface

// File: rtl/param_fifo_mem.sv
// Simple dual-port storage for param_fifo: one write port, one registered read port.
// No reset on the array or read register so it maps onto distributed or block RAM.
module param_fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO controller: pointers, occupancy, registered status flags and sticky errors.
// Storage lives in param_fifo_mem; every output is taken from a register.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AFULL_LVL  = DEPTH - 1,
    parameter int AEMPTY_LVL = 1
) (
    input  logic       clk,
    input  logic       rst,
    param_fifo_if.slave bus
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_nxt;
    flags_t           flags_q;
    flags_t           flags_nxt;
    logic             dvalid_q;
    logic             ovf_q;
    logic             udf_q;
    logic             has_data;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] rd_data;

    // Acceptance uses the registered flags, so a pop never frees room for a same-cycle push.
    assign push = bus.write && !flags_q.full  && !bus.clr;
    assign pop  = bus.read  && !flags_q.empty && !bus.clr;

    always_comb begin
        count_nxt = count_q;
        if (bus.clr)
            count_nxt = '0;
        else if (push && !pop)
            count_nxt = count_q + CNT_ONE;
        else if (pop && !push)
            count_nxt = count_q - CNT_ONE;
    end

    assign flags_nxt = decode_flags(int'(count_nxt), DEPTH, AFULL_LVL, AEMPTY_LVL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            flags_q  <= '{empty: 1'b1, full: 1'b0, aempty: 1'b1, afull: 1'b0};
            dvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            has_data <= 1'b0;
        end else begin
            count_q  <= count_nxt;
            flags_q  <= flags_nxt;
            dvalid_q <= pop;
            if (pop) has_data <= 1'b1;
            if (bus.clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                ovf_q  <= 1'b0;
                udf_q  <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
                if (bus.write && flags_q.full)  ovf_q <= 1'b1;
                if (bus.read  && flags_q.empty) udf_q <= 1'b1;
            end
        end
    end

    param_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.din),
        .re    (pop),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // The RAM read register has no reset; mask it until the first pop after reset.
    assign bus.dout   = has_data ? rd_data : '0;
    assign bus.dvalid = dvalid_q;
    assign bus.empty  = flags_q.empty;
    assign bus.full   = flags_q.full;
    assign bus.aempty = flags_q.aempty;
    assign bus.afull  = flags_q.afull;
    assign bus.count  = count_q;
    assign bus.ovf    = ovf_q;
    assign bus.udf    = udf_q;

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: two configurations, directed scenarios and random traffic,
// all checked against a queue-based model of the FIFO's behaviour.
module tb_param_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    param_fifo_if #(.WIDTH(32), .DEPTH(4))  bus0 ();
    param_fifo_if #(.WIDTH(8),  .DEPTH(16)) bus1 ();

    param_fifo #(.WIDTH(32), .DEPTH(4)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    param_fifo #(.WIDTH(8), .DEPTH(16), .AFULL_LVL(12), .AEMPTY_LVL(3)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int          sel = 0;
    logic        wr  = 1'b0;
    logic        rd  = 1'b0;
    logic        cl  = 1'b0;
    logic [31:0] di  = '0;

    assign bus0.write = (sel == 0) && wr;
    assign bus0.read  = (sel == 0) && rd;
    assign bus0.clr   = (sel == 0) && cl;
    assign bus0.din   = di;
    assign bus1.write = (sel == 1) && wr;
    assign bus1.read  = (sel == 1) && rd;
    assign bus1.clr   = (sel == 1) && cl;
    assign bus1.din   = di[7:0];

    logic [31:0] o_dout;
    logic [31:0] o_count;
    logic [6:0]  o_flags;

    always_comb begin
        o_dout  = 32'(bus0.dout);
        o_count = 32'(bus0.count);
        o_flags = {bus0.dvalid, bus0.empty, bus0.full, bus0.aempty, bus0.afull, bus0.ovf, bus0.udf};
        if (sel == 1) begin
            o_dout  = 32'(bus1.dout);
            o_count = 32'(bus1.count);
            o_flags = {bus1.dvalid, bus1.empty, bus1.full, bus1.aempty, bus1.afull, bus1.ovf, bus1.udf};
        end
    end

    // Reference model: contents as a queue, plus the output/sticky state it implies.
    logic [31:0] q[$];
    logic [31:0] m_dout;
    bit          m_dvalid, m_ovf, m_udf;
    int          depth_m, afl_m, ael_m;
    logic [31:0] mask_m;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s (cfg %0d, t=%0t): observed %0h expected %0h", tag, sel, $time, obs, exp);
        end
    endtask

    task automatic verify_all(input string tag);
        int          cnt;
        logic [6:0]  exp_flags;
        cnt = q.size();
        exp_flags = {m_dvalid, cnt == 0, cnt == depth_m, cnt <= ael_m, cnt >= afl_m, m_ovf, m_udf};
        check({tag, ".count"}, o_count, 32'(cnt));
        check({tag, ".flags"}, 32'(o_flags), 32'(exp_flags));
        check({tag, ".dout"}, o_dout, m_dout);
    endtask

    task automatic model_update(input bit w, input bit r, input bit c, input logic [31:0] d);
        bit was_full, was_empty;
        was_full  = (q.size() == depth_m);
        was_empty = (q.size() == 0);
        if (c) begin
            q.delete();
            m_ovf    = 1'b0;
            m_udf    = 1'b0;
            m_dvalid = 1'b0;
        end else begin
            if (w && was_full)  m_ovf = 1'b1;
            if (r && was_empty) m_udf = 1'b1;
            m_dvalid = r && !was_empty;
            if (r && !was_empty) m_dout = q.pop_front();
            if (w && !was_full)  q.push_back(d & mask_m);
        end
    endtask

    task automatic step(input string tag, input bit w, input bit r, input bit c, input logic [31:0] d);
        wr = w;
        rd = r;
        cl = c;
        di = d;
        @(posedge clk);
        model_update(w, r, c, d);
        #1;
        wr = 1'b0;
        rd = 1'b0;
        cl = 1'b0;
        verify_all(tag);
    endtask

    // Reset asserted between clock edges; outputs are checked before any edge arrives.
    task automatic do_reset(input int s);
        @(negedge clk);
        sel = s;
        if (s == 0) begin
            depth_m = 4;  afl_m = 3;  ael_m = 1; mask_m = 32'hFFFF_FFFF;
        end else begin
            depth_m = 16; afl_m = 12; ael_m = 3; mask_m = 32'h0000_00FF;
        end
        rst = 1'b1;
        #1;
        q.delete();
        m_dout   = '0;
        m_dvalid = 1'b0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        verify_all("reset");
        #2;
        rst = 1'b0;
    endtask

    task automatic run_directed();
        for (int i = 0; i < depth_m; i++) step("fill", 1, 0, 0, 32'hA0 + 32'(i));
        step("ovf", 1, 0, 0, 32'hFF);
        step("ovf_hold", 1, 0, 0, 32'hFF);
        step("full_push_pop", 1, 1, 0, 32'hFF);
        for (int i = 0; i < depth_m; i++) step("drain", 0, 1, 0, 32'h0);
        step("idle", 0, 0, 0, 32'h0);
        step("udf_push", 1, 1, 0, 32'h55);
        step("pop55", 0, 1, 0, 32'h0);
        step("udf_idle", 0, 1, 0, 32'h0);
        step("pre2", 1, 0, 0, 32'h10);
        step("pre2", 1, 0, 0, 32'h11);
        for (int i = 0; i < 10; i++) step("stream", 1, 1, 0, 32'h20 + 32'(i));
        step("post2", 0, 1, 0, 32'h0);
        step("post2", 0, 1, 0, 32'h0);
        for (int i = 0; i < 3; i++) step("pre_clr", 1, 0, 0, 32'h60 + 32'(i));
        step("clr", 1, 1, 1, 32'h77);
        step("after_clr", 0, 1, 0, 32'h0);
        step("after_clr", 1, 0, 0, 32'h88);
        step("after_clr", 0, 1, 0, 32'h0);
        step("mid", 1, 0, 0, 32'h91);
        step("mid", 1, 0, 0, 32'h92);
        do_reset(sel);
        step("post_rst", 1, 0, 0, 32'h93);
        step("post_rst", 0, 1, 0, 32'h0);
    endtask

    task automatic run_random(input int cycles);
        bit w, r, c;
        int pw, pr;
        for (int i = 0; i < cycles; i++) begin
            if (((i / 40) % 2) == 0) begin pw = 80; pr = 30; end
            else                     begin pw = 30; pr = 80; end
            w = ($urandom_range(99) < 32'(pw));
            r = ($urandom_range(99) < 32'(pr));
            c = ($urandom_range(59) == 0);
            step("rand", w, r, c, $urandom);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            do_reset(s);
            run_directed();
            run_random(400);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
